// File: rtl/uart_tx_block_if.sv
// Byte-source side of the UART transmitter.
//   tx_data  : byte to send, sampled on the edge that accepts the request
//   tx_start : request level, honoured only while the transmitter is idle
//   tx_busy  : high while a frame is on the line
//   tx_done  : one-cycle pulse when a frame completes
// master = byte source (host/bus side), slave = transmitter.
interface uart_tx_block_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_block.sv
// UART transmitter: one frame = start bit (0), 8 data bits LSB first, stop bit (1),
// each bit held for CLKS_PER_BIT clocks. All outputs are registered.
// Ports:
//   clk        : system clock, rising edge
//   n_rst      : asynchronous active-low reset
//   bus        : byte-source handshake (tx_data, tx_start in; tx_busy, tx_done out)
//   serial_out : serial line, idles high
module uart_tx_block #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic            clk,
    input  logic            n_rst,
    uart_tx_block_if.slave  bus,
    output logic            serial_out
);

    localparam int unsigned TIMER_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam int unsigned BIT_W      = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]         state_q,  state_d;
    logic [TIMER_W-1:0] timer_q,  timer_d;
    logic [BIT_W-1:0]   bit_q,    bit_d;
    logic [7:0]         shift_q,  shift_d;
    logic               serial_q, serial_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic               bit_end;
    logic [TIMER_W-1:0] timer_adv;

    // Bit-period timer: terminal count ends the current bit and wraps to zero
    assign bit_end   = (timer_q == TIMER_LAST);
    assign timer_adv = bit_end ? '0 : TIMER_W'(timer_q + TIMER_W'(1));

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so the line changes exactly on the bit boundary edge
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (bus.tx_start) begin
                    shift_d  = bus.tx_data;
                    timer_d  = '0;
                    bit_d    = '0;
                    state_d  = ST_START;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            ST_START: begin
                timer_d = timer_adv;
                if (bit_end) begin
                    state_d  = ST_DATA;
                    bit_d    = '0;
                    serial_d = shift_q[0];
                end
            end

            ST_DATA: begin
                timer_d = timer_adv;
                if (bit_end) begin
                    if (bit_q == BIT_W'(7)) begin
                        state_d  = ST_STOP;
                        serial_d = 1'b1;
                    end else begin
                        // Present the next bit now; shifting keeps it at the LSB
                        shift_d  = {1'b0, shift_q[7:1]};
                        bit_d    = BIT_W'(bit_q + BIT_W'(1));
                        serial_d = shift_q[1];
                    end
                end
            end

            ST_STOP: begin
                timer_d = timer_adv;
                if (bit_end) begin
                    state_d  = ST_IDLE;
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                timer_d  = '0;
                bit_d    = '0;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign serial_out  = serial_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_block.sv
// Bench for uart_tx_block: three instances (N = 10, 2, 16) share one clock and reset.
// Expected line/busy/done values come from a frame model: a request accepted at
// edge E0 gives, for cycle offset k after E0, line = frame[(k-1)/N] for k in 1..10N
// with busy high, and line high, busy low, done high at offset 10N+1.
module tb_uart_tx_block;

    logic clk;
    logic n_rst;

    uart_tx_block_if bus0 ();
    uart_tx_block_if bus1 ();
    uart_tx_block_if bus2 ();

    logic so0, so1, so2;

    logic       start_v [3];
    logic [7:0] data_v  [3];
    logic       so_w    [3];
    logic       busy_w  [3];
    logic       done_w  [3];

    int tests_run;
    int tests_failed;

    assign bus0.tx_start = start_v[0];
    assign bus1.tx_start = start_v[1];
    assign bus2.tx_start = start_v[2];
    assign bus0.tx_data  = data_v[0];
    assign bus1.tx_data  = data_v[1];
    assign bus2.tx_data  = data_v[2];

    assign so_w[0]   = so0;
    assign so_w[1]   = so1;
    assign so_w[2]   = so2;
    assign busy_w[0] = bus0.tx_busy;
    assign busy_w[1] = bus1.tx_busy;
    assign busy_w[2] = bus2.tx_busy;
    assign done_w[0] = bus0.tx_done;
    assign done_w[1] = bus1.tx_done;
    assign done_w[2] = bus2.tx_done;

    uart_tx_block #(.CLKS_PER_BIT(10)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .bus(bus0.slave), .serial_out(so0)
    );
    uart_tx_block #(.CLKS_PER_BIT(2)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .bus(bus1.slave), .serial_out(so1)
    );
    uart_tx_block #(.CLKS_PER_BIT(16)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .bus(bus2.slave), .serial_out(so2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_of(input int idx);
        case (idx)
            0:       return 10;
            1:       return 2;
            default: return 16;
        endcase
    endfunction

    task automatic chk(input string tag, input int idx, input int k, input logic got, input logic exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s dut%0d offset %0d: got %b expected %b", tag, idx, k, got, exp);
        end
    endtask

    // Quiet-line checks on every instance for a number of cycles
    task automatic idle_check(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("idle_line", i, c, so_w[i], 1'b1);
                chk("idle_busy", i, c, busy_w[i], 1'b0);
                chk("idle_done", i, c, done_w[i], 1'b0);
            end
        end
    endtask

    // One frame on instance idx. Starts and ends at a negedge. If pre is set the
    // caller already holds tx_start high. noise randomises tx_start/tx_data during
    // the busy cycles; inject_at raises tx_start with 8'hFF at that offset;
    // keep holds tx_start high throughout and leaves it high with next_data at the end.
    task automatic run_frame(input int idx, input logic [7:0] data, input bit pre,
                             input int inject_at, input bit noise, input bit keep,
                             input logic [7:0] next_data);
        int         n;
        logic [9:0] fr;
        n  = n_of(idx);
        fr = {1'b1, data, 1'b0};
        if (!pre) begin
            start_v[idx] = 1'b1;
            data_v[idx]  = data;
        end
        @(posedge clk);
        for (int k = 1; k <= 10 * n + 1; k++) begin
            @(negedge clk);
            if (k <= 10 * n) begin
                chk("frame_line", idx, k, so_w[idx], fr[(k - 1) / n]);
                chk("frame_busy", idx, k, busy_w[idx], 1'b1);
                chk("frame_done", idx, k, done_w[idx], 1'b0);
                if (keep) begin
                    start_v[idx] = 1'b1;
                    data_v[idx]  = data;
                end else if (noise) begin
                    start_v[idx] = 1'($urandom_range(0, 1));
                    data_v[idx]  = 8'($urandom);
                end else begin
                    start_v[idx] = (k == inject_at);
                    data_v[idx]  = (k == inject_at) ? 8'hFF : data;
                end
            end else begin
                chk("end_line", idx, k, so_w[idx], 1'b1);
                chk("end_busy", idx, k, busy_w[idx], 1'b0);
                chk("end_done", idx, k, done_w[idx], 1'b1);
                start_v[idx] = keep;
                data_v[idx]  = next_data;
            end
        end
    endtask

    initial begin
        logic [9:0] fr;
        int         idx;
        tests_run    = 0;
        tests_failed = 0;
        n_rst        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            data_v[i]  = 8'h00;
        end

        // Reset state, then a quiet line with no requests
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_line", i, 0, so_w[i], 1'b1);
            chk("rst_busy", i, 0, busy_w[i], 1'b0);
            chk("rst_done", i, 0, done_w[i], 1'b0);
        end
        n_rst = 1'b1;
        idle_check(50);

        // Single frame 0xA5, one-cycle request
        run_frame(0, 8'hA5, 1'b0, 0, 1'b0, 1'b0, 8'h00);
        idle_check(5);

        // Request at offset 40 while busy is ignored and not queued
        run_frame(0, 8'h3C, 1'b0, 40, 1'b0, 1'b0, 8'h00);
        idle_check(25);

        // Back-to-back with tx_start held high: 0x00 then 0xFF
        run_frame(0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 8'hFF);
        run_frame(0, 8'hFF, 1'b1, 0, 1'b0, 1'b0, 8'h00);
        idle_check(15);

        // Mid-frame reset during data bit 3 of 0x55
        fr = {1'b1, 8'h55, 1'b0};
        start_v[0] = 1'b1;
        data_v[0]  = 8'h55;
        @(posedge clk);
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            chk("pre_rst_line", 0, k, so_w[0], fr[(k - 1) / 10]);
        end
        #1 n_rst = 1'b0;
        #1;
        chk("async_rst_line", 0, 45, so_w[0], 1'b1);
        chk("async_rst_busy", 0, 45, busy_w[0], 1'b0);
        chk("async_rst_done", 0, 45, done_w[0], 1'b0);
        #1 n_rst = 1'b1;
        idle_check(30);
        run_frame(0, 8'h81, 1'b0, 0, 1'b0, 1'b0, 8'h00);
        idle_check(3);

        // Parameter sweep with 0x0F
        run_frame(1, 8'h0F, 1'b0, 0, 1'b0, 1'b0, 8'h00);
        idle_check(3);
        run_frame(2, 8'h0F, 1'b0, 0, 1'b0, 1'b0, 8'h00);
        idle_check(3);

        // Random bytes on random instances with random in-frame request/data noise
        for (int r = 0; r < 12; r++) begin
            idx = int'($urandom_range(0, 2));
            run_frame(idx, 8'($urandom), 1'b0, 0, 1'b1, 1'b0, 8'($urandom));
            idle_check(2);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_block.md
Name: uart_tx_block

Overview:
- UART transmitter: serialises an 8-bit byte into one frame: start bit (0), 8 data bits LSB first, stop bit (1).
- Counterpart of the UART receive path, using the same framing and bit period.
- Sits between the host/bus-side byte source and the serial line.
- Built from a bit-period timer, a bit counter, a load/shift register and a control FSM.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit; legal range >= 2.

Ports:
- clk  input  1  system clock, rising-edge active
- n_rst  input  1  asynchronous, active-low reset
- tx_data  input  8  byte to transmit; sampled only on the accepting edge
- tx_start  input  1  transmit request level; accepted only when FSM is IDLE
- serial_out  output  1  serial line; idles high
- tx_busy  output  1  high while a frame is in progress
- tx_done  output  1  single-cycle pulse at frame completion

Behaviour:
- Clock and reset: one clock (clk); reset n_rst is asynchronous, active-low.
- Reset values: serial_out=1, tx_busy=0, tx_done=0, FSM=IDLE, counters=0, shift register=0.
- Reset mid-frame: all outputs return to their reset values immediately, without waiting for a clock edge. The partial frame is abandoned. No tx_done is produced.
- All outputs are registered; no combinational path from any input to any output.
- N = CLKS_PER_BIT. The edge that accepts a request is E0.
- IDLE:
  - serial_out=1, tx_busy=0.
  - If tx_start=1 at a rising edge: latch tx_data into the shift register, clear the bit-period timer, go to START.
- START:
  - serial_out=0, tx_busy=1, starting the cycle after E0 (latency 1 clock).
  - Held N cycles; after edge E(N) go to DATA with bit index 0.
- DATA:
  - serial_out = current shift-register LSB.
  - Each bit held N cycles, then shift right, bit index +1.
  - After bit 7 completes (edge E(9N)) go to STOP.
- STOP:
  - serial_out=1 for N cycles.
  - After edge E(10N) go to IDLE, drop tx_busy, pulse tx_done=1 for exactly one cycle.
- Timer: counts 0..N-1, width ceil(log2(N)). Terminal count advances the bit, and the timer wraps to 0. Bit counter is 3 bits.
- tx_start while tx_busy=1, including the last STOP cycle: ignored, not queued.
- tx_start held high continuously: a new frame is accepted on the first edge in IDLE, which is the edge where tx_done is high.
  - Back-to-back frame period is therefore 10N+1 cycles.
  - The line stays high for N+1 cycles between frames.
- tx_data changing during a frame has no effect on the frame in progress.
- tx_done and tx_busy are never high in the same cycle. tx_done rises in the cycle tx_busy falls.

Test Plan:
- Reset: n_rst=0, then release, no request -> serial_out=1, tx_busy=0, tx_done=0 for 50 cycles.
- Single frame, N=10, tx_data=8'hA5, one-cycle tx_start:
  - serial_out sequence per 10-cycle slot: 0,1,0,1,0,0,1,0,1,1.
  - tx_busy high for 100 cycles.
  - tx_done pulses once, 100 cycles after the accepting edge.
- Ignored request: 8'h3C accepted; at cycle 40 assert tx_start with tx_data=8'hFF -> frame still shows 0x3C (0,0,0,1,1,1,1,0,0,1); no second frame follows.
- Back-to-back: tx_start held high, data 8'h00 then 8'hFF -> second start bit begins 101 cycles after the first accepting edge; line high 11 cycles between frames.
- Mid-frame reset: pulse n_rst low during data bit 3 of 8'h55 -> serial_out=1 and tx_busy=0 immediately (before the next edge); no tx_done; a next request of 8'h81 transmits correctly.
- Parameter sweep: CLKS_PER_BIT=2 and 16 with tx_data=8'h0F -> each bit exactly N cycles; frame length exactly 10N.
